// File: rtl/karnix_key_conditioner.sv
// karnix_key_conditioner
//   Conditions the raw board push-buttons before they reach the Murax SoC.
//   Each key passes through a two-flop synchroniser and an independent
//   debouncer. The module presents clean pressed levels plus one-cycle
//   press/release pulses. It also generates a stretched SoC reset on
//   power-up and when RESET_KEY is held for a long press.
//
// Ports
//   io_mainClk     : core clock; all logic runs on its rising edge
//   io_reset       : synchronous, active-high reset
//   io_key_raw     : asynchronous raw key pins
//   io_key_level   : debounced key state, 1 = pressed
//   io_key_press   : one-cycle pulse when a debounced level goes 0->1
//   io_key_release : one-cycle pulse when a debounced level goes 1->0
//   io_longPress   : one-cycle pulse when the long-press trigger fires
//   io_sysReset    : active-high stretched reset to the SoC
module karnix_key_conditioner #(
  parameter int KEYS            = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 750000,
  parameter int RESET_KEY       = 3,
  parameter int LONG_CYCLES     = 150000000,
  parameter int RESET_HOLD      = 1024
) (
  input  logic            io_mainClk,
  input  logic            io_reset,
  input  logic [KEYS-1:0] io_key_raw,
  output logic [KEYS-1:0] io_key_level,
  output logic [KEYS-1:0] io_key_press,
  output logic [KEYS-1:0] io_key_release,
  output logic            io_longPress,
  output logic            io_sysReset
);

  localparam int DbW   = $clog2(DEBOUNCE_CYCLES);
  localparam int LongW = $clog2(LONG_CYCLES + 1);
  localparam int HoldW = $clog2(RESET_HOLD + 1);

  localparam logic [KEYS-1:0]  IdleRaw  = ACTIVE_LOW ? {KEYS{1'b1}} : {KEYS{1'b0}};
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LongW-1:0] LongLast = LongW'(LONG_CYCLES - 1);
  localparam logic [LongW-1:0] LongFull = LongW'(LONG_CYCLES);
  localparam logic [HoldW-1:0] HoldInit = HoldW'(RESET_HOLD);

  logic [KEYS-1:0]  sync1_q, sync2_q;
  logic [KEYS-1:0]  sample;
  logic [DbW-1:0]   dbCnt_q [KEYS];
  logic [DbW-1:0]   dbCnt_d [KEYS];
  logic [KEYS-1:0]  toggle;
  logic [KEYS-1:0]  level_q, level_d;
  logic [KEYS-1:0]  press_q, press_d;
  logic [KEYS-1:0]  release_q, release_d;
  logic [LongW-1:0] longCnt_q, longCnt_d;
  logic             armed_q, armed_d;
  logic             trigger;
  logic             longPress_q;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             sysReset_q, sysReset_d;

  // XOR with the idle pattern normalises every sample to 1 = pressed.
  assign sample = sync2_q ^ IdleRaw;

  // A key's level flips only after DEBOUNCE_CYCLES consecutive samples
  // disagree with it; any agreeing sample restarts the count.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < KEYS; i++) begin
      dbCnt_d[i] = '0;
      if (sample[i] != level_q[i]) begin
        if (dbCnt_q[i] == DbLast) begin
          toggle[i] = 1'b1;
        end else begin
          dbCnt_d[i] = dbCnt_q[i] + 1'b1;
        end
      end
    end
    level_d   = level_q ^ toggle;
    press_d   = toggle & ~level_q;
    release_d = toggle & level_q;
  end

  // The counter only advances while armed, so it parks at LONG_CYCLES
  // after firing and one press can produce at most one trigger.
  always_comb begin
    longCnt_d = longCnt_q;
    armed_d   = armed_q;
    trigger   = 1'b0;
    if (!level_q[RESET_KEY]) begin
      longCnt_d = '0;
      armed_d   = 1'b1;
    end else if (armed_q) begin
      if (longCnt_q == LongLast) begin
        trigger   = 1'b1;
        longCnt_d = LongFull;
        armed_d   = 1'b0;
      end else begin
        longCnt_d = longCnt_q + 1'b1;
      end
    end
  end

  // The reset output follows the hold count seen at the edge. Starting
  // from RESET_HOLD, this keeps io_sysReset high for exactly RESET_HOLD
  // edges after io_reset drops. A trigger reloads the count at any time,
  // which can extend a reset that is already in progress.
  always_comb begin
    if (trigger) begin
      hold_d     = HoldInit;
      sysReset_d = 1'b1;
    end else begin
      hold_d     = (hold_q != '0) ? hold_q - 1'b1 : '0;
      sysReset_d = (hold_q != '0);
    end
  end

  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      sync1_q     <= IdleRaw;
      sync2_q     <= IdleRaw;
      for (int i = 0; i < KEYS; i++) dbCnt_q[i] <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      longCnt_q   <= '0;
      armed_q     <= 1'b1;
      longPress_q <= 1'b0;
      hold_q      <= HoldInit;
      sysReset_q  <= 1'b1;
    end else begin
      sync1_q     <= io_key_raw;
      sync2_q     <= sync1_q;
      for (int i = 0; i < KEYS; i++) dbCnt_q[i] <= dbCnt_d[i];
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      longCnt_q   <= longCnt_d;
      armed_q     <= armed_d;
      longPress_q <= trigger;
      hold_q      <= hold_d;
      sysReset_q  <= sysReset_d;
    end
  end

  assign io_key_level   = level_q;
  assign io_key_press   = press_q;
  assign io_key_release = release_q;
  assign io_longPress   = longPress_q;
  assign io_sysReset    = sysReset_q;

endmodule

// File: tb/tb_karnix_key_conditioner.sv
// tb_karnix_key_conditioner
//   Self-checking bench for karnix_key_conditioner. A behavioural model
//   works from a history of raw key samples and tracks press durations.
//   It runs in lock-step with the design, and a random phase follows
//   the directed scenarios.
module tb_karnix_key_conditioner;

  localparam int KEYS  = 4;
  localparam int DEB   = 4;
  localparam int LONGC = 10;
  localparam int HOLD  = 3;
  localparam int RK    = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [KEYS-1:0] raw;
  logic [KEYS-1:0] level, press, release_;
  logic            longPress, sysReset;

  int errorCount = 0;
  int checkCount = 0;

  karnix_key_conditioner #(
    .KEYS(KEYS), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DEB),
    .RESET_KEY(RK), .LONG_CYCLES(LONGC), .RESET_HOLD(HOLD)
  ) dut (
    .io_mainClk(clk),
    .io_reset(reset),
    .io_key_raw(raw),
    .io_key_level(level),
    .io_key_press(press),
    .io_key_release(release_),
    .io_longPress(longPress),
    .io_sysReset(sysReset)
  );

  always #5 clk = ~clk;

  // hist[j] holds the pressed pattern sampled j edges ago. The design
  // judges key stability on samples that are at least two edges old.
  bit [KEYS-1:0] hist [0:DEB+1];
  bit [KEYS-1:0] mLevel, mPress, mRelease;
  bit            mLong, mSys, mFired;
  int            mHeld, mLeft;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input logic rst, input logic [KEYS-1:0] r);
    bit [KEYS-1:0] oldLevel;
    bit            allDiff;
    bit            trig;
    if (rst) begin
      for (int j = 0; j <= DEB + 1; j++) hist[j] = '0;
      mLevel = '0; mPress = '0; mRelease = '0;
      mLong = 1'b0; mFired = 1'b0; mHeld = 0;
      mLeft = HOLD; mSys = 1'b1;
      return;
    end
    oldLevel = mLevel;
    for (int j = DEB + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = ~r;
    for (int k = 0; k < KEYS; k++) begin
      allDiff = 1'b1;
      for (int j = 2; j <= DEB + 1; j++)
        if (hist[j][k] == oldLevel[k]) allDiff = 1'b0;
      mPress[k]   = allDiff && !oldLevel[k];
      mRelease[k] = allDiff && oldLevel[k];
      mLevel[k]   = oldLevel[k] ^ allDiff;
    end
    trig = 1'b0;
    if (!oldLevel[RK]) begin
      mHeld  = 0;
      mFired = 1'b0;
    end else if (!mFired) begin
      mHeld++;
      if (mHeld == LONGC) begin
        trig   = 1'b1;
        mFired = 1'b1;
      end
    end
    mLong = trig;
    if (trig) begin
      mLeft = HOLD;
      mSys  = 1'b1;
    end else begin
      mSys = (mLeft != 0);
      if (mLeft > 0) mLeft--;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [KEYS-1:0] r);
    reset = rst;
    raw   = r;
    @(posedge clk);
    modelStep(rst, r);
    @(negedge clk);
    checkOutput("level",    level,     mLevel);
    checkOutput("press",    press,     mPress);
    checkOutput("release",  release_,  mRelease);
    checkOutput("longPress", longPress, mLong);
    checkOutput("sysReset", sysReset,  mSys);
  endtask

  initial begin
    int pulses;
    int dur;
    logic [KEYS-1:0] pat;
    reset = 1'b1;
    raw   = 4'hF;

    // Power-up reset, then the stretched SoC reset
    applyStimulus(1'b1, 4'hF);
    applyStimulus(1'b1, 4'hF);
    checkOutput("rstLevel", level, 0);
    checkOutput("rstSys", sysReset, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'hF);
      checkOutput("sysRstLen", sysReset, (i < 3));
      checkOutput("idlePress", press, 0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'hF);

    // Single press and release of key 0
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b0, 4'hE);
      checkOutput("k0Level", level[0], (i == 6));
      checkOutput("k0Press", press[0], (i == 6));
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'hE);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b0, 4'hF);
      checkOutput("k0Release", release_[0], (i == 6));
      checkOutput("k0LevelOff", level[0], (i != 6));
    end

    // Glitch shorter than the debounce window on key 1
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'hD);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 4'hF);
      checkOutput("k1Glitch", {level[1], press[1], release_[1]}, 0);
    end

    // Keys 0 and 2 pressed together
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b0, 4'hA);
      checkOutput("dualPress", press, (i == 6) ? 4'h5 : 4'h0);
    end
    checkOutput("dualLevel", level, 4'h5);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'hF);

    // Long press on key 3, twice
    for (int round = 0; round < 2; round++) begin
      pulses = 0;
      for (int i = 1; i <= 30; i++) begin
        applyStimulus(1'b0, 4'h7);
        if (longPress) pulses++;
        checkOutput("longAt", longPress, (i == 16));
        checkOutput("sysRstLong", sysReset, (i >= 16 && i <= 19));
      end
      checkOutput("longOnce", pulses, 1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'hF);
    end

    // io_reset in the middle of a key-2 debounce
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'hB);
    applyStimulus(1'b1, 4'hB);
    checkOutput("abortPress", press, 0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b0, 4'hB);
      checkOutput("k2AfterRst", level[2], (i == 6));
      checkOutput("k2PressAfterRst", press[2], (i == 6));
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'hF);

    // Random phase: hold random patterns for random spans, with the
    // occasional long key-3 hold and a rare reset.
    for (int seg = 0; seg < 120; seg++) begin
      pat = 4'($urandom);
      dur = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 24) : $urandom_range(1, 8);
      for (int i = 0; i < dur; i++) begin
        applyStimulus(($urandom_range(0, 60) == 0), pat);
      end
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
